// File: rtl/l2cache_2way_arb.sv
// l2cache_2way_arb: unified 2-way set-associative write-back / write-allocate
// L2 shared by an L1 instruction cache and an L1 data cache.
//
// Ports
//   clk, proc_reset_n        rising-edge clock, asynchronous active-low reset
//   L1i_read / L1i_addr      instruction read request (held until L1i_ready)
//   L1i_rdata / L1i_ready    instruction read line, one-cycle completion pulse
//   L1d_read / L1d_write     data request (read+write together acts as write)
//   L1d_addr / L1d_wdata     data block address and whole-line write data
//   L1d_rdata / L1d_ready    data read line, one-cycle completion pulse
//   mem_read / mem_write     single shared memory port, held until mem_ready
//   mem_addr / mem_wdata     memory block address, writeback line
//   mem_rdata / mem_ready    fill line and one-cycle memory completion
//   hit_cnt / miss_cnt       saturating counts of first-lookup hits / misses
//
// Handshake: a requester raises its request and holds it; the cache answers
// with exactly one ready cycle, and the requester drops the request on the
// edge that ends that cycle. The memory side is the mirror image: the cache
// holds mem_read or mem_write until a one-cycle mem_ready.
//
// The FSM state is the internal signal r_state (type state_t).
module l2cache_2way_arb #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int SET_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              L1i_read,
  input  logic [ADDR_W-1:0] L1i_addr,
  output logic [LINE_W-1:0] L1i_rdata,
  output logic              L1i_ready,
  input  logic              L1d_read,
  input  logic              L1d_write,
  input  logic [ADDR_W-1:0] L1d_addr,
  input  logic [LINE_W-1:0] L1d_wdata,
  output logic [LINE_W-1:0] L1d_rdata,
  output logic              L1d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int SETS  = 1 << SET_W;
  localparam int TAG_W = ADDR_W - SET_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_ALLOCATE, S_FILL, S_RESPOND
  } state_t;

  state_t r_state, w_next;

  // Transaction context latched at grant. r_side: 0 = I, 1 = D.
  // r_rr names the side that wins the next simultaneous request.
  logic              r_rr, r_side, r_write, r_first, r_victim;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata, r_fill, r_irdata, r_drdata;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  // Per-way state bits are reset; tag and line storage is not.
  logic [SETS-1:0]   r_valid [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag  [2][SETS];
  logic [LINE_W-1:0] r_line [2][SETS];

  logic              w_i_req, w_d_req, w_grant, w_grant_d;
  logic [SET_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
  logic [LINE_W-1:0] w_hit_line;

  assign w_i_req   = L1i_read;
  assign w_d_req   = L1d_read | L1d_write;
  assign w_grant   = w_i_req | w_d_req;
  assign w_grant_d = w_d_req & (~w_i_req | r_rr);

  assign w_idx      = r_addr[SET_W-1:0];
  assign w_tag      = r_addr[ADDR_W-1:SET_W];
  assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_hit_way  = ~w_hit0;
  assign w_hit_line = w_hit0 ? r_line[0][w_idx] : r_line[1][w_idx];
  // Fill an empty way first (way0 preferred); otherwise evict the LRU way.
  assign w_victim   = !r_valid[0][w_idx] ? 1'b0 :
                      (!r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx]);

  assign L1i_rdata = r_irdata;
  assign L1d_rdata = r_drdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    L1i_ready = 1'b0;
    L1d_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)
          w_next = S_RESPOND;
        else if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx])
          w_next = S_WRITEBACK;
        else
          w_next = S_ALLOCATE;
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[r_victim][w_idx], w_idx};
        mem_wdata = r_line[r_victim][w_idx];
        if (mem_ready) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = r_addr;
        if (mem_ready) w_next = S_FILL;
      end
      // The re-lookup after a fill is a guaranteed hit and merges any write.
      S_FILL:    w_next = S_LOOKUP;
      S_RESPOND: begin
        L1i_ready = ~r_side;
        L1d_ready = r_side;
        w_next    = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_rr       <= 1'b0;
      r_side     <= 1'b0;
      r_write    <= 1'b0;
      r_first    <= 1'b0;
      r_victim   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fill     <= '0;
      r_irdata   <= '0;
      r_drdata   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_side  <= w_grant_d;
          r_addr  <= w_grant_d ? L1d_addr : L1i_addr;
          r_write <= w_grant_d & L1d_write;
          r_wdata <= L1d_wdata;
          r_first <= 1'b1;
          if (w_i_req && w_d_req) r_rr <= ~r_rr;
        end
        S_LOOKUP: begin
          r_first <= 1'b0;
          if (r_first) begin
            if (w_hit && r_hit_cnt != '1)
              r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (!w_hit && r_miss_cnt != '1)
              r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
          if (w_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
            if (r_write)     r_dirty[w_hit_way][w_idx] <= 1'b1;
            else if (r_side) r_drdata <= w_hit_line;
            else             r_irdata <= w_hit_line;
          end else begin
            r_victim <= w_victim;
          end
        end
        S_ALLOCATE: if (mem_ready) r_fill <= mem_rdata;
        S_FILL: begin
          r_valid[r_victim][w_idx] <= 1'b1;
          r_dirty[r_victim][w_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP && w_hit && r_write)
      r_line[w_hit_way][w_idx] <= r_wdata;
    if (r_state == S_FILL) begin
      r_line[r_victim][w_idx] <= r_fill;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_l2cache_2way_arb.sv
// Testbench for l2cache_2way_arb (built with CNT_W=4 so counter saturation
// is reachable). A transaction-level cache model predicts read data,
// arbitration order, counters and the exact memory traffic; a memory
// responder with random latency checks every memory request it sees.
module tb_l2cache_2way_arb;
  localparam int AW   = 28;
  localparam int LW   = 128;
  localparam int SW   = 5;
  localparam int CW   = 4;
  localparam int NSET = 1 << SW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, proc_reset_n;
  logic          L1i_read, L1i_ready, L1d_read, L1d_write, L1d_ready;
  logic [AW-1:0] L1i_addr, L1d_addr, mem_addr;
  logic [LW-1:0] L1i_rdata, L1d_rdata, L1d_wdata, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, mem_ready;
  logic [CW-1:0] hit_cnt, miss_cnt;

  l2cache_2way_arb #(.ADDR_W(AW), .LINE_W(LW), .SET_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .L1i_read(L1i_read), .L1i_addr(L1i_addr), .L1i_rdata(L1i_rdata), .L1i_ready(L1i_ready),
    .L1d_read(L1d_read), .L1d_write(L1d_write), .L1d_addr(L1d_addr), .L1d_wdata(L1d_wdata),
    .L1d_rdata(L1d_rdata), .L1d_ready(L1d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } mem_op_t;
  mem_op_t exp_q[$];

  // Behavioural cache model
  bit            m_valid [2][NSET];
  bit            m_dirty [2][NSET];
  logic [AW-1:0] m_blk   [2][NSET];   // full block address held by each way
  logic [LW-1:0] m_line  [2][NSET];
  bit            m_lru   [NSET];
  bit            m_rr;
  int            m_hits, m_misses;
  logic [LW-1:0] last_i, last_d;
  logic [LW-1:0] m_mem    [logic [AW-1:0]];  // model view of memory
  logic [LW-1:0] phys_mem [logic [AW-1:0]];  // what the responder serves
  bit            hold_mem;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {4'h0, a, 4'h1, a ^ 28'h5A5A5A5, 4'h2, ~a, 4'h3, a + 28'd77};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < NSET; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < NSET; s++) m_lru[s] = 1'b0;
    m_rr = 1'b0; m_hits = 0; m_misses = 0;
    last_i = '0; last_d = '0;
  endtask

  // One complete access in the order the cache serves it.
  task automatic model_access(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                              output logic [LW-1:0] rd, output bit hit);
    int s;
    int way;
    s   = int'(a % NSET);
    way = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][s] && m_blk[w][s] == a) way = w;
    hit = (way >= 0);
    if (hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_misses < CMAX) m_misses++;
      if (!m_valid[0][s])      way = 0;
      else if (!m_valid[1][s]) way = 1;
      else                     way = m_lru[s] ? 1 : 0;
      if (m_valid[way][s] && m_dirty[way][s]) begin
        exp_q.push_back({1'b1, m_blk[way][s], m_line[way][s]});
        m_mem[m_blk[way][s]] = m_line[way][s];
      end
      exp_q.push_back({1'b0, a, {LW{1'b0}}});
      m_line[way][s]  = m_mem.exists(a) ? m_mem[a] : init_line(a);
      m_blk[way][s]   = a;
      m_valid[way][s] = 1'b1;
      m_dirty[way][s] = 1'b0;
    end
    if (wr) begin
      m_line[way][s]  = wd;
      m_dirty[way][s] = 1'b1;
      rd = '0;
    end else begin
      rd = m_line[way][s];
    end
    m_lru[s] = (way == 0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int      delay;
    bit      busy;
    mem_op_t op;
    mem_ready = 1'b0;
    mem_rdata = '0;
    busy = 1'b0;
    delay = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!proc_reset_n) begin
        busy = 1'b0;
        continue;
      end
      if (mem_read && mem_write) chk("mem_rw_both", LW'(1), LW'(0));
      if (mem_read || mem_write) begin
        if (!busy) begin
          busy  = 1'b1;
          delay = $urandom_range(0, 3);
          if (exp_q.size() == 0) chk("mem_unexpected", LW'(1), LW'(0));
          else begin
            op = exp_q.pop_front();
            chk("mem_is_write", LW'(mem_write), LW'(op.wr));
            chk("mem_addr", LW'(mem_addr), LW'(op.addr));
            if (op.wr) chk("mem_wdata", mem_wdata, op.data);
          end
        end
        if (!hold_mem) begin
          if (delay == 0) begin
            mem_ready = 1'b1;
            if (mem_write) phys_mem[mem_addr] = mem_wdata;
            else mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_line(mem_addr);
            busy = 1'b0;
          end else begin
            delay--;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_round(input bit di, input bit dd, input bit dwr, input bit drw_both,
                           input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                           input logic [LW-1:0] dwd);
    bit            first_d, hit_i, hit_d, first_hit, pend_i, pend_d;
    logic [LW-1:0] rd_i, rd_d;
    int            cyc, done;
    hit_i = 1'b0; hit_d = 1'b0; rd_i = '0; rd_d = '0;
    @(posedge clk);
    @(negedge clk);
    if (di && dd) begin
      first_d = m_rr;
      m_rr    = ~m_rr;
    end else begin
      first_d = dd;
    end
    if (first_d) begin
      model_access(dwr, ad, dwd, rd_d, hit_d);
      if (di) model_access(1'b0, ai, '0, rd_i, hit_i);
    end else begin
      if (di) model_access(1'b0, ai, '0, rd_i, hit_i);
      if (dd) model_access(dwr, ad, dwd, rd_d, hit_d);
    end
    first_hit = first_d ? hit_d : hit_i;
    L1i_read  = di;
    L1i_addr  = ai;
    L1d_read  = dd && (!dwr || drw_both);
    L1d_write = dd && dwr;
    L1d_addr  = ad;
    L1d_wdata = dwd;
    pend_i = di; pend_d = dd; cyc = 0; done = 0;
    while ((pend_i || pend_d) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (L1i_ready && L1d_ready) chk("both_ready", LW'(1), LW'(0));
      if (done == 0 && (L1i_ready || L1d_ready)) begin
        chk("first_served_d", LW'(L1d_ready), LW'(first_d));
        if (first_hit) chk("hit_latency", LW'(cyc), LW'(2));
      end
      if (L1i_ready) begin
        if (!pend_i) chk("i_spurious_ready", LW'(1), LW'(0));
        else begin
          chk("i_rdata", L1i_rdata, rd_i);
          last_i = rd_i;
          pend_i = 1'b0;
          done++;
          L1i_read = 1'b0;
        end
      end
      if (L1d_ready) begin
        if (!pend_d) chk("d_spurious_ready", LW'(1), LW'(0));
        else begin
          if (dwr) chk("d_rdata_hold", L1d_rdata, last_d);
          else begin
            chk("d_rdata", L1d_rdata, rd_d);
            last_d = rd_d;
          end
          pend_d = 1'b0;
          done++;
          L1d_read  = 1'b0;
          L1d_write = 1'b0;
        end
      end
    end
    if (pend_i || pend_d) chk("round_timeout", LW'(1), LW'(0));
    L1i_read = 1'b0; L1d_read = 1'b0; L1d_write = 1'b0;
    chk("hit_cnt", LW'(hit_cnt), LW'(m_hits));
    chk("miss_cnt", LW'(miss_cnt), LW'(m_misses));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LW-1:0] rd;
    bit            hit;
    bit            seen;
    int            kind;
    logic [AW-1:0] ra_i, ra_d;

    proc_reset_n = 1'b0;
    L1i_read = 1'b0; L1i_addr = '0;
    L1d_read = 1'b0; L1d_write = 1'b0; L1d_addr = '0; L1d_wdata = '0;
    hold_mem = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ready", LW'(L1i_ready), LW'(0));
    chk("rst_d_ready", LW'(L1d_ready), LW'(0));
    chk("rst_mem_read", LW'(mem_read), LW'(0));
    chk("rst_mem_write", LW'(mem_write), LW'(0));
    chk("rst_hit_cnt", LW'(hit_cnt), LW'(0));
    chk("rst_miss_cnt", LW'(miss_cnt), LW'(0));
    chk("rst_i_rdata", L1i_rdata, '0);
    @(negedge clk);
    proc_reset_n = 1'b1;

    // Miss then hit on the instruction side.
    run_round(1, 0, 0, 0, 28'h0000010, '0, '0);
    run_round(1, 0, 0, 0, 28'h0000010, '0, '0);
    // Warm a data line, then two simultaneous hitting pairs (I first, then D first).
    run_round(0, 1, 0, 0, '0, 28'h0000030, '0);
    run_round(1, 1, 0, 0, 28'h0000010, 28'h0000030, '0);
    run_round(1, 1, 0, 0, 28'h0000010, 28'h0000030, '0);
    // Three writes into set 0: the third evicts dirty 0x20 before fetching 0x820.
    run_round(0, 1, 1, 0, '0, 28'h0000020, rand_line());
    run_round(0, 1, 1, 1, '0, 28'h0000420, rand_line());
    run_round(0, 1, 1, 0, '0, 28'h0000820, rand_line());
    // Set 3: fill both ways, hit way0, replace the LRU way1, way0 still hits.
    run_round(1, 0, 0, 0, 28'h0000003, '0, '0);
    run_round(1, 0, 0, 0, 28'h0000023, '0, '0);
    run_round(1, 0, 0, 0, 28'h0000003, '0, '0);
    run_round(0, 1, 0, 0, '0, 28'h0000043, '0);
    run_round(1, 0, 0, 0, 28'h0000003, '0, '0);

    // Random mix over a small address pool (4 sets x 4 tags) forces evictions;
    // the 4-bit counters saturate along the way.
    for (int r = 0; r < 150; r++) begin
      kind = $urandom_range(0, 2);
      ra_i = AW'(($urandom_range(0, 3) << SW) | $urandom_range(0, 3));
      ra_d = AW'(($urandom_range(0, 3) << SW) | $urandom_range(0, 3));
      run_round(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ra_i, ra_d, rand_line());
    end

    // Reset while the cache is waiting in ALLOCATE.
    @(posedge clk);
    @(negedge clk);
    hold_mem = 1'b1;
    model_access(1'b0, 28'hABCDE8, '0, rd, hit);
    L1i_addr = 28'hABCDE8;
    L1i_read = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = mem_read;
    end
    chk("alloc_reached", LW'(seen), LW'(1));
    proc_reset_n = 1'b0;
    L1i_read = 1'b0;
    #1;
    chk("arst_mem_read", LW'(mem_read), LW'(0));
    chk("arst_mem_addr", LW'(mem_addr), LW'(0));
    chk("arst_i_ready", LW'(L1i_ready), LW'(0));
    chk("arst_i_rdata", L1i_rdata, '0);
    chk("arst_hit_cnt", LW'(hit_cnt), LW'(0));
    chk("arst_miss_cnt", LW'(miss_cnt), LW'(0));
    model_reset();
    exp_q.delete();
    hold_mem = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    // Valid bits were cleared, so the earlier line misses again, then hits.
    run_round(1, 0, 0, 0, 28'h0000010, '0, '0);
    run_round(1, 0, 0, 0, 28'h0000010, '0, '0);

    chk("mem_q_empty", LW'(exp_q.size()), LW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
